sdram_arbit: RTL and testbench
==============================

SDRAM_ARBIT -- requirements
Module: sdram_arbit

Interface
REQ-001 Parameter REF_CNT_MAX, default 750, is the auto-refresh interval in clk cycles (15 us at 50 MHz).
REQ-002 Parameter REF_CNT_W, default 10, is the refresh timer width and SHALL satisfy 2^REF_CNT_W > REF_CNT_MAX.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 init_cmd/init_ba/init_addr  input  4/2/12  init sequencer command bus; cmd order is {cs_n,ras_n,cas_n,we_n}.
REQ-006 init_end  input  1  init sequence complete, level.
REQ-007 ref_cmd/ref_ba/ref_addr, ref_end  input  4/2/12, 1  refresh sub-block bus and one-cycle done pulse.
REQ-008 wr_req, wr_end  input  1, 1  write request (level) and one-cycle write done pulse.
REQ-009 wr_cmd/wr_ba/wr_addr, wr_dq, wr_dq_oe  input  4/2/12, 16, 1  write sub-block bus and data drive.
REQ-010 rd_req, rd_end  input  1, 1  read request (level) and one-cycle read done pulse.
REQ-011 rd_cmd/rd_ba/rd_addr  input  4/2/12  read sub-block bus.
REQ-012 ref_en/wr_en/rd_en  output  1 each  grant, high for the whole owning state.
REQ-013 ref_pend  output  1  refresh due; the active write/read SHALL finish its current burst and end.
REQ-014 ref_miss  output  1  sticky flag: refresh interval expired while a refresh was still pending.
REQ-015 sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n  output  1 each  SDRAM control pins.
REQ-016 sdram_bank/sdram_addr  output  2/12  SDRAM bank and address pins.
REQ-017 sdram_dq_out, sdram_dq_oe  output  16, 1  data toward the top-level tristate, and its enable.

Function
REQ-018 States: IDLE, ARBIT, AREF, WRITE, READ; state register only, next state combinational.
REQ-019 IDLE->ARBIT on the first edge with init_end=1; in IDLE the pins carry the init bus.
REQ-020 ARBIT selects in one cycle: ref_pend -> AREF; else wr_req/rd_req -> WRITE/READ.
REQ-021 When wr_req and rd_req are both high in ARBIT, select the type NOT served last (last_wr flag, reset value 0, so write wins first); refresh always has highest priority.
REQ-022 AREF/WRITE/READ -> ARBIT on the edge where ref_end/wr_end/rd_end=1 respectively; end pulses arriving in any other state SHALL be ignored.
REQ-023 In ARBIT, drive cmd NOP (4'b0111), bank 0, addr 0; in AREF/WRITE/READ, mux the owning sub-block's bus combinationally from the state register with zero added latency.
REQ-024 sdram_dq_out = wr_dq; sdram_dq_oe = wr_dq_oe in WRITE, else 0.
REQ-025 Refresh timer holds at 0 until init_end, then counts 0..REF_CNT_MAX-1 and wraps.
REQ-026 On wrap, set ref_pend; clear it on ref_end in AREF.
REQ-027 If wrap and ref_end occur in the same cycle, ref_pend stays 1.
REQ-028 If a wrap occurs while ref_pend=1 and no ref_end is present, set ref_miss; only reset clears it.
REQ-029 ref_en/wr_en/rd_en = (state==AREF/WRITE/READ), registered with state.
REQ-030 sdram_cke = 0 during reset and 1 from the first clock edge after reset deasserts.

Reset
REQ-031 rst asynchronously forces: state IDLE, timer 0, ref_pend 0, ref_miss 0, last_wr 0, all grants 0, sdram_cke 0.
REQ-032 While rst=1, pins follow the IDLE mux (init bus); sdram_dq_oe = 0.
REQ-033 Reset mid-burst abandons the operation; no completion pulse is expected.

Structure
REQ-034 The state encoding and the cmd constants NOP/PRE/AREF/MRS/ACT/WR/RD SHALL live in the shared sdram package used by the init/ref/wr/rd blocks.
REQ-035 The refresh timer plus ref_pend/ref_miss logic SHALL be a sub-module, sdram_ref_timer.

Verification
REQ-036 Reset, then init_end=1 at cycle 10 -> ARBIT at cycle 11, cke=1, pins NOP, and ref_pend=1 exactly 750 cycles after init_end sampled.
REQ-037 wr_req=1 in ARBIT, wr_end at +12 -> wr_en high 12 cycles, pins equal the wr bus, dq_oe follows wr_dq_oe, then ARBIT.
REQ-038 wr_req and rd_req held high, each op 8 cycles -> grants alternate WRITE, READ, WRITE...
REQ-039 ref_pend rises during WRITE -> WRITE finishes at wr_end, next state AREF despite wr_req=1, ref_end clears ref_pend.
REQ-040 ref_end withheld for more than 750 cycles in AREF -> ref_miss=1 and held until rst.
REQ-041 rst pulsed mid-READ -> state IDLE, rd_en=0, dq_oe=0 and cke=0 immediately, without a clock edge.

Source files
------------

// File: rtl/sdram_arbit_pkg.sv
// Shared SDRAM definitions: arbiter state encoding, command constants and the
// command/bank/address bus bundle used by the init, refresh, write and read blocks.
package sdram_arbit_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARBIT,
    ST_AREF,
    ST_WRITE,
    ST_READ
  } arb_state_t;

  // Command order is {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PRE  = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;
  localparam logic [3:0] CMD_MRS  = 4'b0000;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_RD   = 4'b0101;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [1:0]  ba;
    logic [11:0] addr;
  } sdram_bus_t;

endpackage

// File: rtl/sdram_ref_timer.sv
// Auto-refresh interval timer: raises ref_pend every REF_CNT_MAX cycles once init is done,
// and latches ref_miss if an interval expires while the previous refresh is still pending.
module sdram_ref_timer #(
  parameter int REF_CNT_MAX = 750,
  parameter int REF_CNT_W   = 10
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_init_end,
  input  logic i_ref_done,
  output logic o_ref_pend,
  output logic o_ref_miss
);

  localparam logic [REF_CNT_W-1:0] CNT_LAST = REF_CNT_W'(REF_CNT_MAX - 1);

  logic [REF_CNT_W-1:0] r_cnt;
  logic                 r_ref_pend;
  logic                 r_ref_miss;
  logic                 w_wrap;

  assign w_wrap = i_init_end && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (!i_init_end || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A wrap wins over a coincident ref_end: the new interval still needs its own refresh
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ref_pend <= 1'b0;
      r_ref_miss <= 1'b0;
    end else begin
      if (w_wrap) begin
        r_ref_pend <= 1'b1;
      end else if (i_ref_done) begin
        r_ref_pend <= 1'b0;
      end
      if (w_wrap && r_ref_pend && !i_ref_done) begin
        r_ref_miss <= 1'b1;
      end
    end
  end

  assign o_ref_pend = r_ref_pend;
  assign o_ref_miss = r_ref_miss;

endmodule

// File: rtl/sdram_arbit.sv
// SDRAM bus arbiter: hands the command bus to init, refresh, write or read,
// with refresh first and write/read alternating when both are requesting.
module sdram_arbit
  import sdram_arbit_pkg::*;
#(
  parameter int REF_CNT_MAX = 750,
  parameter int REF_CNT_W   = 10
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [3:0]  i_init_cmd,
  input  logic [1:0]  i_init_ba,
  input  logic [11:0] i_init_addr,
  input  logic        i_init_end,
  input  logic [3:0]  i_ref_cmd,
  input  logic [1:0]  i_ref_ba,
  input  logic [11:0] i_ref_addr,
  input  logic        i_ref_end,
  input  logic        i_wr_req,
  input  logic        i_wr_end,
  input  logic [3:0]  i_wr_cmd,
  input  logic [1:0]  i_wr_ba,
  input  logic [11:0] i_wr_addr,
  input  logic [15:0] i_wr_dq,
  input  logic        i_wr_dq_oe,
  input  logic        i_rd_req,
  input  logic        i_rd_end,
  input  logic [3:0]  i_rd_cmd,
  input  logic [1:0]  i_rd_ba,
  input  logic [11:0] i_rd_addr,
  output logic        o_ref_en,
  output logic        o_wr_en,
  output logic        o_rd_en,
  output logic        o_ref_pend,
  output logic        o_ref_miss,
  output logic        o_sdram_cke,
  output logic        o_sdram_cs_n,
  output logic        o_sdram_ras_n,
  output logic        o_sdram_cas_n,
  output logic        o_sdram_we_n,
  output logic [1:0]  o_sdram_bank,
  output logic [11:0] o_sdram_addr,
  output logic [15:0] o_sdram_dq_out,
  output logic        o_sdram_dq_oe
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_last_wr;
  logic       r_ref_en;
  logic       r_wr_en;
  logic       r_rd_en;
  logic       r_cke;
  logic       w_ref_pend;
  logic       w_ref_done;
  sdram_bus_t w_bus;

  assign w_ref_done = i_ref_end && (r_state == ST_AREF);

  sdram_ref_timer #(
    .REF_CNT_MAX (REF_CNT_MAX),
    .REF_CNT_W   (REF_CNT_W)
  ) u_ref_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_init_end (i_init_end),
    .i_ref_done (w_ref_done),
    .o_ref_pend (w_ref_pend),
    .o_ref_miss (o_ref_miss)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= ST_IDLE;
      r_last_wr <= 1'b0;
      r_ref_en  <= 1'b0;
      r_wr_en   <= 1'b0;
      r_rd_en   <= 1'b0;
      r_cke     <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_ref_en <= (w_next == ST_AREF);
      r_wr_en  <= (w_next == ST_WRITE);
      r_rd_en  <= (w_next == ST_READ);
      r_cke    <= 1'b1;
      if (r_state == ST_ARBIT && w_next == ST_WRITE) begin
        r_last_wr <= 1'b1;
      end else if (r_state == ST_ARBIT && w_next == ST_READ) begin
        r_last_wr <= 1'b0;
      end
    end
  end

  // End pulses only count in the state that owns them
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (i_init_end) w_next = ST_ARBIT;
      ST_ARBIT: begin
        if (w_ref_pend) begin
          w_next = ST_AREF;
        end else if (i_wr_req && i_rd_req) begin
          w_next = r_last_wr ? ST_READ : ST_WRITE;
        end else if (i_wr_req) begin
          w_next = ST_WRITE;
        end else if (i_rd_req) begin
          w_next = ST_READ;
        end
      end
      ST_AREF:  if (i_ref_end) w_next = ST_ARBIT;
      ST_WRITE: if (i_wr_end) w_next = ST_ARBIT;
      ST_READ:  if (i_rd_end) w_next = ST_ARBIT;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bus = {CMD_NOP, 2'b00, 12'h000};
    case (r_state)
      ST_IDLE:  w_bus = {i_init_cmd, i_init_ba, i_init_addr};
      ST_AREF:  w_bus = {i_ref_cmd, i_ref_ba, i_ref_addr};
      ST_WRITE: w_bus = {i_wr_cmd, i_wr_ba, i_wr_addr};
      ST_READ:  w_bus = {i_rd_cmd, i_rd_ba, i_rd_addr};
      default:  w_bus = {CMD_NOP, 2'b00, 12'h000};
    endcase
  end

  assign {o_sdram_cs_n, o_sdram_ras_n, o_sdram_cas_n, o_sdram_we_n} = w_bus.cmd;
  assign o_sdram_bank   = w_bus.ba;
  assign o_sdram_addr   = w_bus.addr;
  assign o_sdram_dq_out = i_wr_dq;
  assign o_sdram_dq_oe  = (r_state == ST_WRITE) && i_wr_dq_oe;
  assign o_sdram_cke    = r_cke;
  assign o_ref_pend     = w_ref_pend;
  assign o_ref_en       = r_ref_en;
  assign o_wr_en        = r_wr_en;
  assign o_rd_en        = r_rd_en;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: expected pin/grant snapshots are queued when stimulus
// is applied and compared against the DUT after the clock edge that should produce them.
module tb_sdram_arbit;

  localparam logic [3:0]  INIT_CMD = 4'b0010;
  localparam logic [1:0]  INIT_BA  = 2'd1;
  localparam logic [11:0] INIT_ADR = 12'h400;
  localparam logic [3:0]  REF_CMD  = 4'b0001;
  localparam logic [1:0]  REF_BA   = 2'd2;
  localparam logic [11:0] REF_ADR  = 12'h111;
  localparam logic [3:0]  WR_CMD   = 4'b0100;
  localparam logic [1:0]  WR_BA    = 2'd3;
  localparam logic [11:0] WR_ADR   = 12'h0AB;
  localparam logic [15:0] WR_DQ    = 16'hBEEF;
  localparam logic [3:0]  RD_CMD   = 4'b0101;
  localparam logic [1:0]  RD_BA    = 2'd1;
  localparam logic [11:0] RD_ADR   = 12'h0CD;

  localparam int S_IDLE = 0, S_ARBIT = 1, S_AREF = 2, S_WRITE = 3, S_READ = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        init_end = 1'b0, ref_end = 1'b0;
  logic        wr_req = 1'b0, wr_end = 1'b0, wr_dq_oe = 1'b1;
  logic        rd_req = 1'b0, rd_end = 1'b0;
  logic        ref_en, wr_en, rd_en, ref_pend, ref_miss;
  logic        cke, cs_n, ras_n, cas_n, we_n, dq_oe;
  logic [1:0]  bank;
  logic [11:0] addr;
  logic [15:0] dq_out;

  typedef struct {
    string       tag;
    logic [40:0] val;
  } exp_t;

  exp_t sb[$];
  int   nCmp = 0;
  int   nFail = 0;
  int   edgeCnt = 0;

  always #5 clk = ~clk;

  sdram_arbit dut (
    .i_clk(clk), .i_rst(rst),
    .i_init_cmd(INIT_CMD), .i_init_ba(INIT_BA), .i_init_addr(INIT_ADR), .i_init_end(init_end),
    .i_ref_cmd(REF_CMD), .i_ref_ba(REF_BA), .i_ref_addr(REF_ADR), .i_ref_end(ref_end),
    .i_wr_req(wr_req), .i_wr_end(wr_end), .i_wr_cmd(WR_CMD), .i_wr_ba(WR_BA),
    .i_wr_addr(WR_ADR), .i_wr_dq(WR_DQ), .i_wr_dq_oe(wr_dq_oe),
    .i_rd_req(rd_req), .i_rd_end(rd_end), .i_rd_cmd(RD_CMD), .i_rd_ba(RD_BA), .i_rd_addr(RD_ADR),
    .o_ref_en(ref_en), .o_wr_en(wr_en), .o_rd_en(rd_en),
    .o_ref_pend(ref_pend), .o_ref_miss(ref_miss), .o_sdram_cke(cke),
    .o_sdram_cs_n(cs_n), .o_sdram_ras_n(ras_n), .o_sdram_cas_n(cas_n), .o_sdram_we_n(we_n),
    .o_sdram_bank(bank), .o_sdram_addr(addr), .o_sdram_dq_out(dq_out), .o_sdram_dq_oe(dq_oe)
  );

  // Reference snapshot: {grants, pend, miss, cke, cmd, bank, addr, dq_oe, dq_out}
  function automatic logic [40:0] model(int st, logic pend, logic miss, logic ck);
    logic [2:0]  g;
    logic [17:0] pins;
    logic        oe;
    g    = 3'b000;
    oe   = 1'b0;
    pins = {4'b0111, 2'b00, 12'h000};
    case (st)
      S_IDLE:  pins = {INIT_CMD, INIT_BA, INIT_ADR};
      S_AREF:  begin g = 3'b100; pins = {REF_CMD, REF_BA, REF_ADR}; end
      S_WRITE: begin g = 3'b010; pins = {WR_CMD, WR_BA, WR_ADR}; oe = wr_dq_oe; end
      S_READ:  begin g = 3'b001; pins = {RD_CMD, RD_BA, RD_ADR}; end
      default: ;
    endcase
    return {g, pend, miss, ck, pins, oe, WR_DQ};
  endfunction

  function automatic logic [40:0] observed();
    return {ref_en, wr_en, rd_en, ref_pend, ref_miss, cke,
            cs_n, ras_n, cas_n, we_n, bank, addr, dq_oe, dq_out};
  endfunction

  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      edgeCnt++;
    end
  endtask

  task automatic pushExpected(input string tag, input int st, input logic pend,
                              input logic miss, input logic ck);
    exp_t e;
    e.tag = tag;
    e.val = model(st, pend, miss, ck);
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [40:0] o;
    o = observed();
    nCmp++;
    if (sb.size() == 0) begin
      nFail++;
      $error("[TB] FAIL scoreboard_empty observed=%h required=none", o);
    end else begin
      e = sb.pop_front();
      assert (o === e.val) else begin
        nFail++;
        $error("[TB] FAIL %s observed=%h required=%h", e.tag, o, e.val);
      end
    end
  endtask

  task automatic waitUntil(input int n);
    while (edgeCnt < n) applyStimulus(1);
  endtask

  initial begin
    // Reset asserted with no clock edge: init bus on pins, cke low, dq_oe low
    #1 rst = 1'b1;
    #1;
    pushExpected("reset_async", S_IDLE, 0, 0, 0);
    checkOutput();
    applyStimulus(2);
    rst = 1'b0;
    pushExpected("cke_after_reset", S_IDLE, 0, 0, 1);
    applyStimulus(1);
    checkOutput();

    applyStimulus(9);
    init_end = 1'b1;
    pushExpected("idle_before_init_edge", S_IDLE, 0, 0, 1);
    checkOutput();
    pushExpected("arbit_after_init", S_ARBIT, 0, 0, 1);
    applyStimulus(1);
    checkOutput();
    edgeCnt = 0;

    // Both requests held: write first after reset, then strict alternation
    wr_req = 1'b1;
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      automatic bit isWr = (i % 2 == 0);
      pushExpected(isWr ? "alt_write_grant" : "alt_read_grant", isWr ? S_WRITE : S_READ, 0, 0, 1);
      applyStimulus(1);
      checkOutput();
      applyStimulus(3);
      if (isWr) rd_end = 1'b1; else wr_end = 1'b1;
      pushExpected("foreign_end_ignored", isWr ? S_WRITE : S_READ, 0, 0, 1);
      applyStimulus(1);
      rd_end = 1'b0;
      wr_end = 1'b0;
      checkOutput();
      applyStimulus(3);
      if (isWr) wr_end = 1'b1; else rd_end = 1'b1;
      if (i == 3) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
      pushExpected("alt_back_to_arbit", S_ARBIT, 0, 0, 1);
      applyStimulus(1);
      wr_end = 1'b0;
      rd_end = 1'b0;
      checkOutput();
    end

    // Single 12-cycle write with dq_oe passthrough
    wr_req = 1'b1;
    pushExpected("write_grant", S_WRITE, 0, 0, 1);
    applyStimulus(1);
    wr_req = 1'b0;
    checkOutput();
    for (int k = 2; k <= 12; k++) begin
      if (k == 6) wr_dq_oe = 1'b0;
      if (k == 10) wr_dq_oe = 1'b1;
      applyStimulus(1);
      pushExpected("write_hold", S_WRITE, 0, 0, 1);
      checkOutput();
    end
    wr_end = 1'b1;
    pushExpected("write_done_arbit", S_ARBIT, 0, 0, 1);
    applyStimulus(1);
    wr_end = 1'b0;
    checkOutput();

    // First refresh request exactly one interval after init_end
    waitUntil(748);
    pushExpected("ref_pend_not_yet", S_ARBIT, 0, 0, 1);
    checkOutput();
    pushExpected("ref_pend_rise", S_ARBIT, 1, 0, 1);
    applyStimulus(1);
    checkOutput();
    pushExpected("aref_grant", S_AREF, 1, 0, 1);
    applyStimulus(1);
    checkOutput();
    applyStimulus(2);
    wr_end = 1'b1;
    pushExpected("aref_ignores_wr_end", S_AREF, 1, 0, 1);
    applyStimulus(1);
    wr_end = 1'b0;
    checkOutput();
    applyStimulus(1);
    ref_end = 1'b1;
    pushExpected("aref_done_clears_pend", S_ARBIT, 0, 0, 1);
    applyStimulus(1);
    ref_end = 1'b0;
    checkOutput();

    // Refresh comes due mid-write: write completes, then refresh beats the held wr_req
    waitUntil(1490);
    wr_req = 1'b1;
    applyStimulus(1);
    waitUntil(1498);
    pushExpected("write_before_wrap", S_WRITE, 0, 0, 1);
    checkOutput();
    pushExpected("pend_during_write", S_WRITE, 1, 0, 1);
    applyStimulus(1);
    checkOutput();
    waitUntil(1502);
    wr_end = 1'b1;
    pushExpected("write_end_with_pend", S_ARBIT, 1, 0, 1);
    applyStimulus(1);
    wr_end = 1'b0;
    checkOutput();
    pushExpected("aref_beats_wr_req", S_AREF, 1, 0, 1);
    applyStimulus(1);
    checkOutput();
    wr_req = 1'b0;

    // Refresh withheld across a full interval
    waitUntil(2248);
    pushExpected("miss_not_yet", S_AREF, 1, 0, 1);
    checkOutput();
    pushExpected("miss_set", S_AREF, 1, 1, 1);
    applyStimulus(1);
    checkOutput();
    waitUntil(2998);
    ref_end = 1'b1;
    pushExpected("wrap_with_ref_end_keeps_pend", S_ARBIT, 1, 1, 1);
    applyStimulus(1);
    ref_end = 1'b0;
    checkOutput();
    pushExpected("aref_again", S_AREF, 1, 1, 1);
    applyStimulus(1);
    checkOutput();
    applyStimulus(1);
    ref_end = 1'b1;
    pushExpected("miss_sticky", S_ARBIT, 0, 1, 1);
    applyStimulus(1);
    ref_end = 1'b0;
    checkOutput();

    // Reset pulsed in the middle of a read
    rd_req = 1'b1;
    pushExpected("read_grant", S_READ, 0, 1, 1);
    applyStimulus(1);
    rd_req = 1'b0;
    checkOutput();
    applyStimulus(2);
    rst = 1'b1;
    #1;
    pushExpected("reset_mid_read", S_IDLE, 0, 0, 0);
    checkOutput();
    applyStimulus(2);
    pushExpected("reset_held", S_IDLE, 0, 0, 0);
    checkOutput();
    rst = 1'b0;
    pushExpected("arbit_after_rereset", S_ARBIT, 0, 0, 1);
    applyStimulus(1);
    checkOutput();

    if (sb.size() != 0) begin
      nFail++;
      $display("[TB] FAIL scoreboard_leftover observed=%0d required=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
